alu_operand_loader: RTL and testbench

- Front-end stage that sits directly upstream of the 4-bit ALU and drives its `a`, `b`, `s1` and `s0` inputs.
- Operator sets 4 slide switches and presses a LOAD push button three times: first to capture A, then B, then the opcode.
- Raw buttons are synchronised and debounced; a 4-state FSM sequences the captures and flags when a complete operand set is presented to the ALU.

---
 rtl/alu_operand_loader.sv | 178 +++++++++++++++++
 tb/tb_alu_operand_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// Operand loader for a 4-bit ALU: debounced LOAD/CLEAR buttons sequence captures of A, B and opcode.
// Define ALU_OPLOAD_SHADOW_EN to stage captures in shadow registers and publish them atomically.
module alu_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn_load,
  input  logic       btn_clear,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       s1,
  output logic       s0,
  output logic [1:0] stage,
  output logic       ready
);

  typedef enum logic [1:0] {
    StLoadA  = 2'd0,
    StLoadB  = 2'd1,
    StLoadOp = 2'd2,
    StRun    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is LOAD, bit 1 is CLEAR.
  logic [1:0]       raw_btn;
  logic [1:0]       sync1_q, btn_s_q;
  logic [1:0]       db_q, db_d, db_dly_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       pulse;
  logic             load_pulse, clear_pulse;

  assign raw_btn     = {btn_clear, btn_load};
  assign pulse       = db_q & ~db_dly_q;
  assign load_pulse  = pulse[0];
  assign clear_pulse = pulse[1];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      db_d[i]  = db_q[i];
      if (btn_s_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        db_d[i]  = btn_s_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      btn_s_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q  <= raw_btn;
      btn_s_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [1:0] op_q, op_d;
  logic       ready_q, ready_d;
`ifdef ALU_OPLOAD_SHADOW_EN
  logic [3:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [1:0] sh_op_q, sh_op_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    ready_d = ready_q;
`ifdef ALU_OPLOAD_SHADOW_EN
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_op_d = sh_op_q;
`endif
    // Clear has priority; a coincident load pulse is dropped.
    if (clear_pulse) begin
      state_d = StLoadA;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      ready_d = 1'b0;
`ifdef ALU_OPLOAD_SHADOW_EN
      sh_a_d  = '0;
      sh_b_d  = '0;
      sh_op_d = '0;
`endif
    end else if (load_pulse) begin
      unique case (state_q)
        StLoadA: begin
`ifdef ALU_OPLOAD_SHADOW_EN
          sh_a_d = sw;
`else
          a_d    = sw;
`endif
          state_d = StLoadB;
        end
        StLoadB: begin
`ifdef ALU_OPLOAD_SHADOW_EN
          sh_b_d = sw;
`else
          b_d    = sw;
`endif
          state_d = StLoadOp;
        end
        StLoadOp: begin
`ifdef ALU_OPLOAD_SHADOW_EN
          sh_op_d = sw[1:0];
          a_d     = sh_a_q;
          b_d     = sh_b_q;
`endif
          op_d    = sw[1:0];
          state_d = StRun;
          ready_d = 1'b1;
        end
        StRun: begin
          state_d = StLoadA;
          ready_d = 1'b0;
        end
        default: state_d = StLoadA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoadA;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      ready_q <= 1'b0;
`ifdef ALU_OPLOAD_SHADOW_EN
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_op_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      ready_q <= ready_d;
`ifdef ALU_OPLOAD_SHADOW_EN
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_op_q <= sh_op_d;
`endif
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign s1    = op_q[1];
  assign s0    = op_q[0];
  assign stage = state_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with DEBOUNCE_CYCLES=4; expectations follow ALU_OPLOAD_SHADOW_EN.
module tb_alu_operand_loader;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn_load;
  logic       btn_clear;
  logic [3:0] a, b;
  logic       s1, s0;
  logic [1:0] stage;
  logic       ready;

  int errors = 0;
  int checks = 0;

  alu_operand_loader #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .btn_load (btn_load),
    .btn_clear(btn_clear),
    .a        (a),
    .b        (b),
    .s1       (s1),
    .s0       (s0),
    .stage    (stage),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic [3:0] sw;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [1:0] eop;
    logic [1:0] est;
    logic       er;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                           input logic [1:0] eop, input logic [1:0] est, input logic er);
    check({tag, ".a"}, int'(a), int'(ea));
    check({tag, ".b"}, int'(b), int'(eb));
    check({tag, ".op"}, int'({s1, s0}), int'(eop));
    check({tag, ".stage"}, int'(stage), int'(est));
    check({tag, ".ready"}, int'(ready), int'(er));
  endtask

  task automatic press(input logic clr, input logic [3:0] val);
    sw = val;
    @(negedge clk);
    if (clr) btn_clear = 1'b1;
    else     btn_load  = 1'b1;
    repeat (10) @(negedge clk);
    btn_clear = 1'b0;
    btn_load  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic set_vec(input int i, input logic clr, input logic [3:0] s, input logic [3:0] ea,
                         input logic [3:0] eb, input logic [1:0] eop, input logic [1:0] est,
                         input logic er);
    tbl[i] = '{clr: clr, sw: s, ea: ea, eb: eb, eop: eop, est: est, er: er};
  endtask

  initial begin
`ifdef ALU_OPLOAD_SHADOW_EN
    set_vec(0,  1'b0, 4'h5, 4'h0, 4'h0, 2'b00, 2'd1, 1'b0);
    set_vec(1,  1'b0, 4'h3, 4'h0, 4'h0, 2'b00, 2'd2, 1'b0);
    set_vec(2,  1'b0, 4'hD, 4'h5, 4'h3, 2'b01, 2'd3, 1'b1);
    set_vec(3,  1'b0, 4'h9, 4'h5, 4'h3, 2'b01, 2'd0, 1'b0);
    set_vec(4,  1'b0, 4'h9, 4'h5, 4'h3, 2'b01, 2'd1, 1'b0);
    set_vec(5,  1'b0, 4'h2, 4'h5, 4'h3, 2'b01, 2'd2, 1'b0);
    set_vec(6,  1'b0, 4'hE, 4'h9, 4'h2, 2'b10, 2'd3, 1'b1);
    set_vec(7,  1'b1, 4'h0, 4'h0, 4'h0, 2'b00, 2'd0, 1'b0);
    set_vec(8,  1'b0, 4'hF, 4'h0, 4'h0, 2'b00, 2'd1, 1'b0);
    set_vec(9,  1'b0, 4'h6, 4'h0, 4'h0, 2'b00, 2'd2, 1'b0);
    set_vec(10, 1'b1, 4'h0, 4'h0, 4'h0, 2'b00, 2'd0, 1'b0);
    set_vec(11, 1'b0, 4'h7, 4'h0, 4'h0, 2'b00, 2'd1, 1'b0);
`else
    set_vec(0,  1'b0, 4'h5, 4'h5, 4'h0, 2'b00, 2'd1, 1'b0);
    set_vec(1,  1'b0, 4'h3, 4'h5, 4'h3, 2'b00, 2'd2, 1'b0);
    set_vec(2,  1'b0, 4'hD, 4'h5, 4'h3, 2'b01, 2'd3, 1'b1);
    set_vec(3,  1'b0, 4'h9, 4'h5, 4'h3, 2'b01, 2'd0, 1'b0);
    set_vec(4,  1'b0, 4'h9, 4'h9, 4'h3, 2'b01, 2'd1, 1'b0);
    set_vec(5,  1'b0, 4'h2, 4'h9, 4'h2, 2'b01, 2'd2, 1'b0);
    set_vec(6,  1'b0, 4'hE, 4'h9, 4'h2, 2'b10, 2'd3, 1'b1);
    set_vec(7,  1'b1, 4'h0, 4'h0, 4'h0, 2'b00, 2'd0, 1'b0);
    set_vec(8,  1'b0, 4'hF, 4'hF, 4'h0, 2'b00, 2'd1, 1'b0);
    set_vec(9,  1'b0, 4'h6, 4'hF, 4'h6, 2'b00, 2'd2, 1'b0);
    set_vec(10, 1'b1, 4'h0, 4'h0, 4'h0, 2'b00, 2'd0, 1'b0);
    set_vec(11, 1'b0, 4'h7, 4'h7, 4'h0, 2'b00, 2'd1, 1'b0);
`endif

    rst_n     = 1'b0;
    sw        = 4'h0;
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    #3;
    check_all("reset", 4'h0, 4'h0, 2'b00, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Raw rise before edge 1: capture lands on edge 7 (N+3).
    sw       = 4'h5;
    btn_load = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("lat_edge6.stage", int'(stage), 0);
    @(posedge clk);
    #1;
    check("lat_edge7.stage", int'(stage), 1);
`ifndef ALU_OPLOAD_SHADOW_EN
    check("lat_edge7.a", int'(a), 5);
`endif
    @(negedge clk);
    btn_load = 1'b0;
    repeat (12) @(negedge clk);
    press(1'b1, 4'h0);
    check_all("lat_clear", 4'h0, 4'h0, 2'b00, 2'd0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      press(tbl[i].clr, tbl[i].sw);
      check_all($sformatf("vec%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].eop, tbl[i].est, tbl[i].er);
    end

    // Glitches of 3 and 2 cycles are shorter than the debounce window.
    sw = 4'h4;
    @(negedge clk);
    btn_load = 1'b1;
    repeat (3) @(negedge clk);
    btn_load = 1'b0;
    @(negedge clk);
    btn_load = 1'b1;
    repeat (2) @(negedge clk);
    btn_load = 1'b0;
    repeat (12) @(negedge clk);
    check("bounce_reject.stage", int'(stage), 1);
    press(1'b0, 4'h4);
    check("bounce_hold.stage", int'(stage), 2);
`ifndef ALU_OPLOAD_SHADOW_EN
    check("bounce_hold.b", int'(b), 4);
`endif

    // Both buttons pressed together and held long: clear wins, no repeat.
    @(negedge clk);
    btn_load  = 1'b1;
    btn_clear = 1'b1;
    repeat (30) @(negedge clk);
    check_all("simul", 4'h0, 4'h0, 2'b00, 2'd0, 1'b0);
    btn_load  = 1'b0;
    btn_clear = 1'b0;
    repeat (12) @(negedge clk);

    press(1'b0, 4'h3);
    check("pre_areset.stage", int'(stage), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("areset", 4'h0, 4'h0, 2'b00, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
